// File: rtl/kompleks_delitel.sv
// kompleks_delitel: sequential signed complex divider (p_re + i*p_im) / (d_re + i*d_im)
module kompleks_delitel #(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic signed [2*W-1:0] p_re,
   input  logic signed [2*W-1:0] p_im,
   input  logic signed [W-1:0]   d_re,
   input  logic signed [W-1:0]   d_im,
   output logic                  busy,
   output logic                  done,
   output logic signed [W-1:0]   q_re,
   output logic signed [W-1:0]   q_im,
   output logic                  dz,
   output logic                  ovf
);
   localparam int NW = 3*W+1;
   localparam int DW = 2*W;
   localparam int PW = 3*W;
   localparam int CW = $clog2(NW);
   localparam logic [NW-1:0] LIM = NW'(1) << (W-1);
   typedef enum logic [2:0] {IDLE, MUL, DIV_RE, DIV_IM, FIN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic signed [2*W-1:0] pr, pi;
   logic signed [W-1:0] dr, di;
   logic signed [W-1:0] mul_a;
   logic signed [2*W-1:0] mul_b;
   logic signed [PW-1:0] prod;
   logic signed [NW-1:0] prod_x, num_re, num_im;
   logic [DW-1:0] den, rem;
   logic [DW:0] trial;
   logic [NW-1:0] quo, quo_nx, mag_re, mag_im, abs_re, abs_im;
   logic [W-1:0] sq_re, sq_im;
   logic accept, fit, last, dz_c, c_re, c_im;

   // clip = magnitude outside the signed W-bit range for the given sign
   function automatic logic [W:0] sat(input logic neg, input logic [NW-1:0] mag);
      logic clip;
      clip = neg ? mag > LIM : mag >= LIM;
      return {clip, clip ? {neg, {(W-1){~neg}}} : (neg ? -mag[W-1:0] : mag[W-1:0])};
   endfunction

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = accept ? MUL : IDLE;
         MUL:     state_nx = cnt == CW'(7) ? DIV_RE : MUL;
         DIV_RE:  state_nx = last ? DIV_IM : DIV_RE;
         DIV_IM:  state_nx = last ? FIN : DIV_IM;
         default: state_nx = IDLE;
      endcase
   end

   // product order: d_re^2, d_im^2, p_re*d_re, p_im*d_im, p_im*d_re, p_re*d_im
   always_comb begin
      accept = start & ~busy;
      mul_a = cnt[0] ? di : dr;
      mul_b = cnt < CW'(2) ? {{W{mul_a[W-1]}}, mul_a} : (cnt == CW'(3) || cnt == CW'(4)) ? pi : pr;
      prod_x = {{(NW-PW){prod[PW-1]}}, prod};
      abs_re = num_re[NW-1] ? -num_re : num_re;
      abs_im = num_im[NW-1] ? -num_im : num_im;
      trial = {rem, quo[NW-1]};
      fit = trial >= {1'b0, den};
      quo_nx = {quo[NW-2:0], fit};
      last = cnt == CW'(NW-1);
      dz_c = den == '0;
      {c_re, sq_re} = sat(num_re[NW-1], mag_re);
      {c_im, sq_im} = sat(num_im[NW-1], mag_im);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         pr <= '0;
         pi <= '0;
         dr <= '0;
         di <= '0;
         prod <= '0;
         den <= '0;
         num_re <= '0;
         num_im <= '0;
         rem <= '0;
         quo <= '0;
         mag_re <= '0;
         mag_im <= '0;
         q_re <= '0;
         q_im <= '0;
         dz <= 1'b0;
         ovf <= 1'b0;
      end else begin
         cnt <= state_nx != state ? '0 : cnt + 1'b1;
         prod <= mul_a * mul_b;
         done <= state == FIN;
         busy <= accept | (busy & ~done);
         if (accept) begin
            pr <= p_re;
            pi <= p_im;
            dr <= d_re;
            di <= d_im;
            den <= '0;
            num_re <= '0;
            num_im <= '0;
         end
         if (state == MUL) begin
            if (cnt == CW'(1) || cnt == CW'(2)) den <= den + prod_x[DW-1:0];
            if (cnt == CW'(3) || cnt == CW'(4)) num_re <= num_re + prod_x;
            if (cnt == CW'(5)) num_im <= num_im + prod_x;
            if (cnt == CW'(6)) num_im <= num_im - prod_x;
            if (cnt == CW'(7)) begin
               rem <= '0;
               quo <= abs_re;
            end
         end
         if (state == DIV_RE || state == DIV_IM) begin
            rem <= fit ? DW'(trial - {1'b0, den}) : trial[DW-1:0];
            quo <= quo_nx;
            if (last && state == DIV_RE) begin
               mag_re <= quo_nx;
               rem <= '0;
               quo <= abs_im;
            end
            if (last && state == DIV_IM) mag_im <= quo_nx;
         end
         if (state == FIN) begin
            q_re <= dz_c ? '0 : sq_re;
            q_im <= dz_c ? '0 : sq_im;
            dz <= dz_c;
            ovf <= ~dz_c & (c_re | c_im);
         end
      end
endmodule

// File: tb/tb_kompleks_delitel.sv
// tb_kompleks_delitel: directed vectors against a cycle-level arithmetic model of the divider
module tb_kompleks_delitel;
   typedef struct packed {
      logic signed [7:0] re;
      logic signed [7:0] im;
      logic z;
      logic o;
   } res_t;
   logic clk = 1'b0;
   logic rst, start;
   logic signed [15:0] p_re, p_im;
   logic signed [7:0] d_re, d_im;
   logic busy, done, dz, ovf;
   logic signed [7:0] q_re, q_im;
   int n_chk = 0;
   int n_fail = 0;
   bit m_act = 0;
   int m_age = 0;
   res_t pend = '0;
   res_t h = '0;

   kompleks_delitel #(.W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .p_re(p_re), .p_im(p_im), .d_re(d_re), .d_im(d_im),
      .busy(busy), .done(done), .q_re(q_re), .q_im(q_im), .dz(dz), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input int pr, input int pi, input int dr, input int di);
      res_t r;
      longint den, a, b;
      den = longint'(dr*dr + di*di);
      r = '0;
      if (den == 0) r.z = 1'b1;
      else begin
         a = longint'(pr*dr + pi*di) / den;
         b = longint'(pi*dr - pr*di) / den;
         r.o = a > 127 || a < -128 || b > 127 || b < -128;
         a = a > 127 ? 127 : a < -128 ? -128 : a;
         b = b > 127 ? 127 : b < -128 ? -128 : b;
         r.re = 8'(a);
         r.im = 8'(b);
      end
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // m_age counts edges since the accepting edge; the result appears after edge 59
   always @(posedge clk or posedge rst)
      if (rst) begin
         m_act <= 0;
         m_age <= 0;
         h <= '0;
      end else if (m_act) begin
         m_age <= m_age + 1;
         if (m_age == 58) h <= pend;
         if (m_age == 59) m_act <= 0;
      end else if (start) begin
         m_act <= 1;
         m_age <= 0;
         pend <= model(p_re, p_im, d_re, d_im);
      end

   always @(negedge clk) begin
      chk("busy", busy, int'(m_act));
      chk("done", done, int'(m_act && m_age == 59));
      chk("q_re", q_re, h.re);
      chk("q_im", q_im, h.im);
      chk("dz", dz, int'(h.z));
      chk("ovf", ovf, int'(h.o));
   end

   task automatic run(input int a, input int b, input int c, input int d, input bit poke,
                      input int er, input int ei, input int ez, input int eo);
      int n;
      @(posedge clk);
      #1;
      chk("busy before start", busy, 0);
      p_re = 16'(a);
      p_im = 16'(b);
      d_re = 8'(c);
      d_im = 8'(d);
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      p_re = 16'sh1234;
      p_im = -16'sd777;
      d_re = 8'sd3;
      d_im = -8'sd9;
      chk("busy after accept", busy, 1);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
         if (poke && n == 10) begin
            start = 1;
            p_re = 16'sd1000;
            d_re = 8'sd1;
         end
         if (poke && n == 11) start = 0;
      end
      chk("latency", n, 60);
      chk("lit q_re", q_re, er);
      chk("lit q_im", q_im, ei);
      chk("lit dz", dz, ez);
      chk("lit ovf", ovf, eo);
   endtask

   initial begin
      int dn;
      rst = 1;
      start = 0;
      p_re = 0;
      p_im = 0;
      d_re = 0;
      d_im = 0;
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset q_re", q_re, 0);
      chk("reset dz", dz, 0);
      rst = 0;
      run(-6, -102, -10, 4, 0, -3, 9, 0, 0);
      run(86, -76, -12, 2, 0, -8, 5, 0, 0);
      run(7, 0, 2, 0, 0, 3, 0, 0, 0);
      run(-7, 0, 2, 0, 0, -3, 0, 0, 0);
      run(1000, -1000, 1, 0, 0, 127, -128, 0, 1);
      run(5, 5, 0, 0, 0, 0, 0, 1, 0);
      run(-29, 31, -7, 2, 0, 5, -3, 0, 0);
      run(-6, -102, -10, 4, 1, -3, 9, 0, 0);
      dn = 0;
      repeat (70) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("extra done after ignored start", dn, 0);
      @(posedge clk);
      #1;
      p_re = 86;
      p_im = -76;
      d_re = -12;
      d_im = 2;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      repeat (30) @(negedge clk);
      #1 rst = 1;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort q_re", q_re, 0);
      chk("abort q_im", q_im, 0);
      chk("abort dz", dz, 0);
      chk("abort ovf", ovf, 0);
      repeat (3) @(negedge clk);
      rst = 0;
      dn = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("done after abort", dn, 0);
      run(7, 0, 2, 0, 0, 3, 0, 0, 0);
      run(-1184, 740, 0, 1, 0, 127, 127, 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/kompleks_delitel.md
Name: kompleks_delitel

Overview:
- Sequential signed complex divider: (p_re + i·p_im) / (d_re + i·d_im) -> (q_re + i·q_im).
- Inverse of the team's complex multiplier: recovers one factor from a product and the other factor.
- Uses one shared registered W x 2W real multiplier, time-multiplexed, plus one iterative restoring divider used twice.
- Sits downstream of the multiplier chain; also used to self-check it.

Parameters:
W, 8, factor/quotient component width (signed); product components are 2W wide, numerator NW=3W+1, denominator DW=2W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; sampled only when busy=0
p_re  in  2W  dividend real part, signed
p_im  in  2W  dividend imaginary part, signed
d_re  in  W  divisor real part, signed
d_im  in  W  divisor imaginary part, signed
busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive
done  out  1  one-cycle pulse; results valid from this cycle
q_re  out  W  quotient real part, signed
q_im  out  W  quotient imaginary part, signed
dz  out  1  divisor was 0+0i
ovf  out  1  at least one quotient component saturated

Behaviour:
- Reset values (async, immediate): busy=0, done=0, q_re=0, q_im=0, dz=0, ovf=0, FSM=IDLE, all internal registers 0.
- Acceptance:
  - start=1 with busy=0 latches p_re, p_im, d_re and d_im at that edge.
  - start while busy=1 is ignored; no queuing.
- Math, full precision with no intermediate truncation:
  - den = d_re² + d_im², unsigned DW bits. Max is 2·128² = 32768 for W=8.
  - num_re = p_re·d_re + p_im·d_im, signed NW bits.
  - num_im = p_im·d_re − p_re·d_im, signed NW bits.
- FSM: IDLE -> MUL -> DIV_RE -> DIV_IM -> FIN -> IDLE.
- MUL state, 8 cycles:
  - Issues 6 products to the registered multiplier, one per cycle: d_re², d_im², p_re·d_re, p_im·d_im, p_im·d_re, p_re·d_im.
  - Each product is captured one cycle after issue and accumulated into den, num_re or num_im.
  - Operands are sign-extended to 2W before multiplying.
- DIV_RE / DIV_IM, NW cycles each:
  - Unsigned restoring division of |num| by den, one quotient bit per cycle, MSB first.
  - Result sign = sign(num); rounding truncates toward zero.
- FIN state:
  - Saturates each signed quotient to [−2^(W−1), 2^(W−1)−1].
  - ovf = either component clipped.
  - Registers q_re, q_im, dz and ovf, and pulses done.
- Fixed latency: done rises exactly LAT = 8 + 2·NW + 1 = 59 cycles (W=8) after the accepting edge, independent of operand values.
- Divide by zero (den=0):
  - Division iterations still run to keep latency fixed.
  - FIN forces q_re=q_im=0, dz=1, ovf=0.
- Output holding:
  - q_re, q_im, dz and ovf hold their values until the next done, or until reset.
  - They do not change at start.
- Back-to-back: start is accepted in the cycle after done (busy=0 then); there is no dead cycle beyond that.
- Reset mid-operation:
  - Abort immediately and return to reset values.
  - No done for the aborted request.
  - The next start after rst deasserts behaves normally.
- Exact results: inputs that are true products of W-bit complex factors return the original factor exactly, with ovf=0.

Test Plan:
- p=(−6,−102), d=(−10,4), start at T -> done at T+59, q=(−3,9), dz=0, ovf=0 (den=116, num=(−348,1044)).
- p=(86,−76), d=(−12,2) issued the cycle after the previous done -> q=(−8,5), ovf=0; busy is low for exactly one cycle between the two requests.
- Truncation: p=(7,0), d=(2,0) -> q=(3,0); p=(−7,0), d=(2,0) -> q=(−3,0); both ovf=0.
- Saturation: p=(1000,−1000), d=(1,0) -> q=(127,−128), ovf=1, dz=0.
- Divide by zero: p=(5,5), d=(0,0) -> done at T+59, q=(0,0), dz=1, ovf=0.
- Control:
  - Pulse start again 10 cycles into a request -> ignored; only one done; first request's result is correct.
  - Assert rst at cycle 30 of a request -> busy, done, q and flags drop to 0 asynchronously; no done follows.
  - A fresh request after rst deasserts completes correctly.
